// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the core data port and a word-wide SRAM bus.
// Aligns byte/half/word accesses into strobed word transactions and extends load data.
module dmem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_wen;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_legal;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    assign w_accept  = i_req_valid & (r_state == S_IDLE);
    assign w_timeout = (r_cnt == TMO);

    // Unsigned variants are load-only; half and word need natural alignment.
    always_comb begin
        w_legal = 1'b0;
        case (i_req_op)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~i_req_addr[0];
            3'b010:  w_legal = (i_req_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~i_req_wen;
            3'b101:  w_legal = ~i_req_wen & ~i_req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = i_req_wdata;
        case (i_req_op[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            2'b10:   w_wstrb = 4'b1111;
            default: w_wstrb = 4'b0000;
        endcase
        if (!i_req_wen) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_shift = i_mem_rdata >> {r_lane, 3'b000};
        case (r_op)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = i_mem_rdata;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A timeout only fires when no completion arrives in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_legal ? S_REQ : S_RESP;
            S_REQ:  if (i_mem_gnt) w_next = S_WAIT;
            S_WAIT: if (i_mem_rvalid || w_timeout) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wen       <= 1'b0;
            r_op        <= 3'd0;
            r_lane      <= 2'd0;
            r_cnt       <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= (w_next == S_RESP);
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            if (w_next == S_RESP) begin
                r_rsp_err <= (r_state == S_IDLE) | ~i_mem_rvalid;
                if ((r_state == S_WAIT) && i_mem_rvalid && !r_wen) begin
                    r_rsp_rdata <= w_load;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wen  <= i_req_wen;
                        r_op   <= i_req_op;
                        r_lane <= i_req_addr[1:0];
                        if (w_legal) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_req_wen;
                            r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                            r_mem_wstrb <= w_wstrb;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid || w_timeout) begin
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wstrb = r_mem_wstrb;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed spec scenarios plus randomized accesses
// compared against a byte-level reference model of the load/store rules.
module tb_dmem_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, reqReady, reqWen;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr, reqWdata;
    logic        rspValid, rspErr;
    logic [31:0] rspRdata;
    logic        memReq, memWe, memGnt, memRvalid;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memWstrb;

    int tests = 0;
    int fails = 0;

    logic        obReady0, obErr, obReqSeen, obWe, obStable, obPulseOk, obHung;
    int          obLat;
    logic [31:0] obRdata, obAddr, obWdata;
    logic [3:0]  obStrb;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_wen(reqWen),
        .i_req_op(reqOp), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid), .o_rsp_rdata(rspRdata), .o_rsp_err(rspErr),
        .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr),
        .o_mem_wstrb(memWstrb), .o_mem_wdata(memWdata),
        .i_mem_gnt(memGnt), .i_mem_rvalid(memRvalid), .i_mem_rdata(memRdata)
    );

    // Reference model: access size in bytes, legality, strobes, replication, extension.
    function automatic int accSize(input logic [2:0] op);
        int o = int'(op) % 4;
        return (o == 0) ? 1 : (o == 1) ? 2 : 4;
    endfunction

    function automatic logic expLegal(input logic wen, input logic [2:0] op, input logic [1:0] a);
        int o = int'(op);
        if (o == 3 || o >= 6) return 1'b0;
        if (wen && o >= 4) return 1'b0;
        if ((int'(a) % accSize(op)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] expStrb(input logic [2:0] op, input logic [1:0] a);
        int m = ((1 << accSize(op)) - 1) << int'(a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] op, input logic [31:0] d);
        if (accSize(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (accSize(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rd);
        longint v = longint'(rd) / (longint'(1) << (8 * int'(a)));
        int bits = 8 * accSize(op);
        longint val = v % (longint'(1) << bits);
        if (int'(op) < 4 && bits < 32 && val >= (longint'(1) << (bits - 1)))
            val = val - (longint'(1) << bits);
        return 32'(val);
    endfunction

    // Runs one access against a bus responder and records what the DUT did.
    task automatic drive_access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int gntWait, input int rvWait, input logic stray);
        int c = 1, reqc = 0, w = 0;
        logic granted = 1'b0;
        obReady0 = reqReady; obErr = 0; obReqSeen = 0; obWe = 0; obStable = 1;
        obPulseOk = 1; obHung = 0; obLat = -1; obRdata = 0; obAddr = 0; obWdata = 0; obStrb = 0;
        reqValid = 1; reqWen = wen; reqOp = op; reqAddr = addr; reqWdata = wdata;
        @(posedge clk); #1;
        reqValid = 0; reqWen = 1'($urandom); reqOp = 3'($urandom); reqAddr = $urandom; reqWdata = $urandom;
        while (c < 200) begin
            if (rspValid) begin
                obLat = c; obErr = rspErr; obRdata = rspRdata;
                break;
            end
            if (memReq) begin
                if (granted) obStable = 0;
                if (!obReqSeen) begin
                    obAddr = memAddr; obWe = memWe; obStrb = memWstrb; obWdata = memWdata;
                end else if (memAddr !== obAddr || memWe !== obWe || memWstrb !== obStrb || memWdata !== obWdata) begin
                    obStable = 0;
                end
                obReqSeen = 1;
                if (reqc == gntWait) begin
                    memGnt = 1; granted = 1;
                end else if (stray) begin
                    memRvalid = 1; memRdata = $urandom;
                end
                reqc++;
            end else if (granted) begin
                if (memAddr !== obAddr || memWe !== obWe || memWstrb !== obStrb || memWdata !== obWdata)
                    obStable = 0;
                if (w == rvWait) begin
                    memRvalid = 1; memRdata = rdata;
                end else if (stray) begin
                    memGnt = 1;
                end
                w++;
            end
            @(posedge clk); #1;
            memGnt = 0; memRvalid = 0; memRdata = $urandom;
            c++;
        end
        if (c >= 200) begin
            obHung = 1;
        end else begin
            @(posedge clk); #1;
            obPulseOk = !rspValid && reqReady;
        end
    endtask

    task automatic test_reset();
        rstN = 0; reqValid = 0; reqWen = 0; reqOp = 0; reqAddr = 0; reqWdata = 0;
        memGnt = 0; memRvalid = 0; memRdata = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (rspValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %b exp 0", rspValid); end
        tests++; if (rspRdata !== 32'd0) begin fails++; $display("[TB] FAIL reset_rsp_rdata got %h exp 0", rspRdata); end
        tests++; if (rspErr !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_err got %b exp 0", rspErr); end
        tests++; if (memReq !== 1'b0 || memWe !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req_we got %b%b exp 00", memReq, memWe); end
        tests++; if (memAddr !== 32'd0 || memWstrb !== 4'd0 || memWdata !== 32'd0) begin fails++; $display("[TB] FAIL reset_mem_fields got %h/%b/%h exp 0", memAddr, memWstrb, memWdata); end
        rstN = 1;
        @(posedge clk); #1;
        tests++; if (reqReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_req_ready got %b exp 1", reqReady); end
    endtask

    task automatic test_store_byte();
        drive_access(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0);
        tests++; if (obLat !== 3) begin fails++; $display("[TB] FAIL sb_latency got %0d exp 3", obLat); end
        tests++; if (obErr !== 1'b0) begin fails++; $display("[TB] FAIL sb_err got %b exp 0", obErr); end
        tests++; if (obStrb !== 4'b1000) begin fails++; $display("[TB] FAIL sb_wstrb got %b exp 1000", obStrb); end
        tests++; if (obWdata !== 32'hABAB_ABAB) begin fails++; $display("[TB] FAIL sb_wdata got %h exp ababab ab", obWdata); end
        tests++; if (obAddr !== 32'h8000_0000) begin fails++; $display("[TB] FAIL sb_addr got %h exp 80000000", obAddr); end
        tests++; if (obWe !== 1'b1) begin fails++; $display("[TB] FAIL sb_we got %b exp 1", obWe); end
        tests++; if (obRdata !== 32'd0) begin fails++; $display("[TB] FAIL sb_rdata got %h exp 0", obRdata); end
        tests++; if (obPulseOk !== 1'b1) begin fails++; $display("[TB] FAIL sb_pulse got %b exp 1", obPulseOk); end
    endtask

    task automatic test_loads();
        logic [2:0]  ops[5]   = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [1:0]  offs[5]  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] wants[5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 5; i++) begin
            drive_access(1'b0, ops[i], 32'h8000_0000 + 32'(offs[i]), 32'h0, 32'h80FF_7F01, 0, 0, 1'b0);
            tests++; if (obRdata !== wants[i]) begin fails++; $display("[TB] FAIL load%0d_rdata got %h exp %h", i, obRdata, wants[i]); end
            tests++; if (obErr !== 1'b0 || obLat !== 3) begin fails++; $display("[TB] FAIL load%0d_err_lat got %b/%0d exp 0/3", i, obErr, obLat); end
            tests++; if (obStrb !== 4'b0000) begin fails++; $display("[TB] FAIL load%0d_wstrb got %b exp 0000", i, obStrb); end
        end
    endtask

    task automatic test_illegal();
        logic        wens[3]  = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  ops[3]   = '{3'b010, 3'b011, 3'b100};
        logic [31:0] addrs[3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};
        for (int i = 0; i < 3; i++) begin
            drive_access(wens[i], ops[i], addrs[i], 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 1'b0);
            tests++; if (obLat !== 1 || obErr !== 1'b1) begin fails++; $display("[TB] FAIL illegal%0d_lat_err got %0d/%b exp 1/1", i, obLat, obErr); end
            tests++; if (obReqSeen !== 1'b0) begin fails++; $display("[TB] FAIL illegal%0d_mem_req got %b exp 0", i, obReqSeen); end
            tests++; if (obRdata !== 32'd0) begin fails++; $display("[TB] FAIL illegal%0d_rdata got %h exp 0", i, obRdata); end
        end
    endtask

    task automatic test_grant_stall();
        drive_access(1'b1, 3'b001, 32'h1000_0006, 32'h1234_BEEF, 32'h0, 5, 0, 1'b1);
        tests++; if (obStable !== 1'b1) begin fails++; $display("[TB] FAIL stall_stable got %b exp 1", obStable); end
        tests++; if (obLat !== 8) begin fails++; $display("[TB] FAIL stall_latency got %0d exp 8", obLat); end
        tests++; if (obStrb !== 4'b1100 || obWdata !== 32'hBEEF_BEEF) begin fails++; $display("[TB] FAIL stall_fields got %b/%h exp 1100/beefbeef", obStrb, obWdata); end
        tests++; if (obErr !== 1'b0) begin fails++; $display("[TB] FAIL stall_err got %b exp 0", obErr); end
    endtask

    task automatic test_timeout();
        drive_access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h5555_5555, 0, -1, 1'b0);
        tests++; if (obLat !== 2 + TMO + 1) begin fails++; $display("[TB] FAIL timeout_latency got %0d exp %0d", obLat, 2 + TMO + 1); end
        tests++; if (obErr !== 1'b1 || obRdata !== 32'd0) begin fails++; $display("[TB] FAIL timeout_err_rdata got %b/%h exp 1/0", obErr, obRdata); end
        tests++; if (obPulseOk !== 1'b1) begin fails++; $display("[TB] FAIL timeout_ready_after got %b exp 1", obPulseOk); end
    endtask

    task automatic test_back_to_back();
        drive_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 0, 0, 1'b0);
        tests++; if (obReady0 !== 1'b1 || obRdata !== 32'hA5A5_0F0F) begin fails++; $display("[TB] FAIL b2b_first got %b/%h exp 1/a5a50f0f", obReady0, obRdata); end
        drive_access(1'b1, 3'b010, 32'h0000_0044, 32'h0BAD_F00D, 32'h0, 0, 0, 1'b0);
        tests++; if (obReady0 !== 1'b1 || obLat !== 3) begin fails++; $display("[TB] FAIL b2b_second got %b/%0d exp 1/3", obReady0, obLat); end
    endtask

    task automatic test_random();
        logic [2:0] legalOps[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            logic        wen = 1'($urandom);
            logic [2:0]  op  = ($urandom_range(0, 9) < 7) ? legalOps[$urandom_range(0, 4)] : 3'($urandom);
            logic [31:0] addr = $urandom, wd = $urandom, rd = $urandom;
            int          gw = $urandom_range(0, 3);
            int          rv = int'($urandom_range(0, 6)) - 1;
            logic        lg = expLegal(wen, op, addr[1:0]);
            logic        tmo = lg && (rv < 0 || rv > TMO);
            int          eLat = !lg ? 1 : tmo ? 3 + gw + TMO : 3 + gw + rv;
            logic [31:0] eRd = (lg && !tmo && !wen) ? expLoad(op, addr[1:0], rd) : 32'd0;
            drive_access(wen, op, addr, wd, rd, gw, rv, 1'($urandom));
            tests++; if (obHung !== 1'b0 || obLat !== eLat) begin fails++; $display("[TB] FAIL rnd%0d_latency got %0d exp %0d", i, obLat, eLat); end
            tests++; if (obErr !== (!lg || tmo)) begin fails++; $display("[TB] FAIL rnd%0d_err got %b exp %b", i, obErr, (!lg || tmo)); end
            tests++; if (obRdata !== eRd) begin fails++; $display("[TB] FAIL rnd%0d_rdata got %h exp %h", i, obRdata, eRd); end
            tests++; if (obReqSeen !== lg) begin fails++; $display("[TB] FAIL rnd%0d_mem_req got %b exp %b", i, obReqSeen, lg); end
            tests++; if (obPulseOk !== 1'b1 || obReady0 !== 1'b1) begin fails++; $display("[TB] FAIL rnd%0d_handshake got %b%b exp 11", i, obPulseOk, obReady0); end
            if (lg) begin
                tests++; if (obAddr !== (addr & 32'hFFFF_FFFC) || obWe !== wen) begin fails++; $display("[TB] FAIL rnd%0d_addr_we got %h/%b exp %h/%b", i, obAddr, obWe, addr & 32'hFFFF_FFFC, wen); end
                tests++; if (obStrb !== (wen ? expStrb(op, addr[1:0]) : 4'd0)) begin fails++; $display("[TB] FAIL rnd%0d_wstrb got %b exp %b", i, obStrb, wen ? expStrb(op, addr[1:0]) : 4'd0); end
                tests++; if (obStable !== 1'b1) begin fails++; $display("[TB] FAIL rnd%0d_stable got %b exp 1", i, obStable); end
                if (wen) begin
                    tests++; if (obWdata !== expWdata(op, wd)) begin fails++; $display("[TB] FAIL rnd%0d_wdata got %h exp %h", i, obWdata, expWdata(op, wd)); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        reqValid = 1; reqWen = 1; reqOp = 3'b010; reqAddr = 32'h4000_0008; reqWdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reqValid = 0; memGnt = 1;
        @(posedge clk); #1;
        memGnt = 0;
        tests++; if (memWe !== 1'b1 || memAddr !== 32'h4000_0008) begin fails++; $display("[TB] FAIL mid_pre_fields got %b/%h exp 1/40000008", memWe, memAddr); end
        @(posedge clk); #1;
        rstN = 0; #1;
        tests++; if (memWe !== 1'b0 || memAddr !== 32'd0 || memWdata !== 32'd0 || memWstrb !== 4'd0 || memReq !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_mem got %b%b/%h/%b/%h exp 0", memReq, memWe, memAddr, memWstrb, memWdata); end
        tests++; if (rspValid !== 1'b0 || rspErr !== 1'b0 || rspRdata !== 32'd0) begin fails++; $display("[TB] FAIL mid_reset_rsp got %b/%b/%h exp 0", rspValid, rspErr, rspRdata); end
        #2; rstN = 1;
        for (int i = 0; i < 4; i++) begin
            memRvalid = 1; memRdata = $urandom;
            @(posedge clk); #1;
            tests++; if (rspValid !== 1'b0 || memReq !== 1'b0) begin fails++; $display("[TB] FAIL mid_stray%0d got %b/%b exp 0/0", i, rspValid, memReq); end
        end
        memRvalid = 0;
        tests++; if (reqReady !== 1'b1) begin fails++; $display("[TB] FAIL mid_ready got %b exp 1", reqReady); end
        drive_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hF00D_0000, 1, 1, 1'b0);
        tests++; if (obRdata !== 32'h0000_F00D || obLat !== 5) begin fails++; $display("[TB] FAIL mid_recover got %h/%0d exp 0000f00d/5", obRdata, obLat); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_illegal();
        test_grant_stall();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no finish exp finish before 400us");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
